// File: rtl/sram_pkg.sv
// Shared types and constants for the external asynchronous SRAM controller.
package sram_pkg;

  localparam int DATA_W  = 16;
  localparam int HOST_AW = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Host-side request/response bundle between the A/B buffer mux and sram_ctrl.
interface sram_ctrl_if;
  import sram_pkg::*;

  logic                start;
  logic                rw;
  logic [HOST_AW-1:0]  addr;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W-1:0]   data_out;
  logic                ready;

  modport master (
    output start, rw, addr, data_in,
    input  data_out, ready
  );

  modport slave (
    input  start, rw, addr, data_in,
    output data_out, ready
  );

endinterface

// File: rtl/sram_dq_pad.sv
// Tristate driver for the SRAM data bus plus read-capture path.
// SRAM_DQ_INREG_EN: capture dq into an I/O-cell register first, load data_out one edge later.
module sram_dq_pad
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drive,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cap_access,
  input  logic              cap_hold,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_load,
  inout  wire  [DATA_W-1:0] sram_dq
);

  assign sram_dq = drive ? wr_data : 'z;

`ifdef SRAM_DQ_INREG_EN
  logic [DATA_W-1:0] dq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dq_q <= '0;
    else if (cap_access) dq_q <= sram_dq;
  end

  assign rd_data = dq_q;
  assign rd_load = cap_hold;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, cap_hold};

  assign rd_data = sram_dq;
  assign rd_load = cap_access;
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Single-port controller for the external asynchronous 16-bit SRAM: IDLE/SETUP/ACCESS/HOLD
// strobe sequencing with registered outputs. Optional macro: SRAM_DQ_INREG_EN (see sram_dq_pad).
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned SRAM_AW  = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_ctrl_if.slave         host,
  output logic [SRAM_AW-1:0] sram_a,
  inout  wire  [DATA_W-1:0]  sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  if (WAIT_CYC < 1) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYC must be >= 1");
  end
  if (SRAM_AW < HOST_AW) begin : g_bad_aw
    $error("sram_ctrl: SRAM_AW must be >= 16");
  end

  localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rw_q;
  logic [DATA_W-1:0]  wr_q;
  logic               drive;
  logic               cap_access;
  logic               cap_hold;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_load;

  assign cap_access = (state == ACCESS) && (cnt == CNT_LAST) && (rw_q == RW_READ);
  assign cap_hold   = (state == HOLD) && (rw_q == RW_READ);

  sram_dq_pad u_pad (
    .clk        (clk),
    .rst_n      (rst_n),
    .drive      (drive),
    .wr_data    (wr_q),
    .cap_access (cap_access),
    .cap_hold   (cap_hold),
    .rd_data    (rd_data),
    .rd_load    (rd_load),
    .sram_dq    (sram_dq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rw_q          <= RW_READ;
      wr_q          <= '0;
      drive         <= 1'b0;
      host.ready    <= 1'b1;
      host.data_out <= '0;
      sram_a        <= '0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
    end else begin
      if (rd_load) host.data_out <= rd_data;

      case (state)
        IDLE: begin
          if (host.start) begin
            rw_q       <= host.rw;
            wr_q       <= host.data_in;
            sram_a     <= SRAM_AW'(host.addr);
            host.ready <= 1'b0;
            sram_ce_n  <= 1'b0;
            sram_ub_n  <= 1'b0;
            sram_lb_n  <= 1'b0;
            // Read enables oe_n in SETUP; write drives dq early for address/data setup.
            if (host.rw == RW_READ) begin
              sram_oe_n <= 1'b0;
              drive     <= 1'b0;
            end else begin
              drive     <= 1'b1;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          cnt <= '0;
          if (rw_q == RW_WRITE) sram_we_n <= 1'b0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          host.ready <= 1'b1;
          sram_ce_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          drive      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl against a phase-timeline reference and SRAM model.
module tb_sram_ctrl;
  import sram_pkg::*;

`ifdef SRAM_DQ_INREG_EN
  localparam int unsigned W = 1;
`else
  localparam int unsigned W = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();

  wire  [15:0] sram_dq;
  logic [19:0] sram_a;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  sram_ctrl #(.WAIT_CYC(W), .SRAM_AW(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (bus),
    .sram_a    (sram_a),
    .sram_dq   (sram_dq),
    .sram_ce_n (ce_n),
    .sram_oe_n (oe_n),
    .sram_we_n (we_n),
    .sram_ub_n (ub_n),
    .sram_lb_n (lb_n)
  );

  // Asynchronous SRAM chip model: drives on ce/oe, stores on we_n rising.
  logic [15:0] sram_mem [0:65535];
  assign sram_dq = (!ce_n && !oe_n) ? sram_mem[sram_a[15:0]] : 16'bz;
  always @(posedge we_n) if (!ce_n) sram_mem[sram_a[15:0]] = sram_dq;

  logic [15:0] ref_mem [0:65535];
  logic [15:0] exp_dout;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {bus.ready, ce_n, oe_n, we_n, ub_n, lb_n, dut.u_pad.drive};
  endfunction

  // One request: timeline k=0 SETUP, 1..W ACCESS, W+1 HOLD, W+2 back in IDLE.
  task automatic run_access(input logic r, input logic [15:0] a, input logic [15:0] d,
                            input bit hold, input bit poke);
    int unsigned t;
    logic [6:0] e;
    t = 0;
    while (!bus.ready && t < 20) begin @(negedge clk); t++; end
    chk("entry_ready", bus.ready, 1);
    bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    bus.rw = ~r; bus.addr = 16'($urandom); bus.data_in = 16'($urandom);
    for (int k = 0; k <= int'(W) + 2; k++) begin
      if (k > 0) @(negedge clk);
      e[6]   = (k == int'(W) + 2);
      e[5]   = (k == int'(W) + 2);
      e[4]   = !(r && k <= int'(W));
      e[3]   = !(!r && k >= 1 && k <= int'(W));
      e[2]   = e[5];
      e[1]   = e[5];
      e[0]   = !r && k <= int'(W) + 1;
      chk($sformatf("ctl_%s_k%0d", r ? "rd" : "wr", k), ctl_vec(), e);
      if (k <= int'(W) + 1) begin
        chk("sram_a", sram_a, {4'h0, a});
        if (!r) chk("wr_dq", sram_dq, d);
        else if (k <= int'(W)) chk("rd_dq", sram_dq, ref_mem[a]);
      end
      if (k == int'(W) + 1) begin
`ifdef SRAM_DQ_INREG_EN
        chk("dout_hold", bus.data_out, exp_dout);
`else
        chk("dout_hold", bus.data_out, r ? ref_mem[a] : exp_dout);
`endif
      end
      if (poke && k == 1) begin bus.start = 1'b1; bus.rw = RW_READ; bus.addr = 16'h0001; end
      if (poke && k == 2) bus.start = 1'b0;
      if (k == int'(W) + 2) begin
        if (r) exp_dout = ref_mem[a];
        else begin
          ref_mem[a] = d;
          chk("mem_write", sram_mem[a], d);
        end
        chk("dout", bus.data_out, exp_dout);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin sram_mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    exp_dout = 16'h0;
    bus.start = 1'b0; bus.rw = RW_READ; bus.addr = '0; bus.data_in = '0;
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_ctl", ctl_vec(), 7'b1111110);
      chk("reset_dout", bus.data_out, 16'h0);
      chk("reset_addr", sram_a, 20'h0);
    end

    run_access(RW_WRITE, 16'h0012, 16'hBEEF, 0, 0);
    run_access(RW_READ,  16'h0012, 16'h0000, 0, 0);
    chk("readback", bus.data_out, 16'hBEEF);

    // Start pulse mid-write must be dropped, not queued.
    run_access(RW_WRITE, 16'h0040, 16'h1234, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_queue", {bus.ready, ce_n}, 2'b11);
    end
    chk("dout_after_ignored", bus.data_out, 16'hBEEF);

    // Back-to-back with start held: writes then reads of 0..2.
    for (int i = 0; i < 3; i++)
      run_access(RW_WRITE, 16'(i), 16'hA000 + 16'(i), i < 2, 0);
    for (int i = 0; i < 3; i++)
      run_access(RW_READ, 16'(i), 16'h0, i < 2, 0);
    chk("b2b_last", bus.data_out, 16'hA002);

    for (int n = 0; n < 40; n++) begin
      run_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom), 0, 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Asynchronous reset in the ACCESS phase of a write.
    bus.start = 1'b1; bus.rw = RW_WRITE; bus.addr = 16'h0FFF; bus.data_in = 16'h5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_reset_we", we_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", ctl_vec(), 7'b1111110);
    chk("async_rst_dout", bus.data_out, 16'h0);
    exp_dout = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.ready, 1'b1);

    run_access(RW_READ, 16'h0012, 16'h0, 0, 0);
    for (int n = 0; n < 10; n++)
      run_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
